inst_sram_ctrl: RTL and testbench

//  RAM-side responder for the instruction-fetch handshake (ram_need_to_work / ram_work_done / ram_feed_back).

---
 rtl/inst_sram_if.sv | 49 ++++
 rtl/inst_sram_ctrl.sv | 176 +++++++++++++++++
 tb/tb_inst_sram_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/inst_sram_if.sv
// Bus bundle between the instruction-fetch requester and inst_sram_ctrl, plus the board SRAM pins.
// The write-port signals exist only when SRAM_WRITE_EN is defined.
interface inst_sram_if #(
  parameter int ADDR_W = 18
);
  logic [15:0]       addr;
  logic              ram_need_to_work;
  logic              ram_work_done;
  logic [15:0]       ram_feed_back;
  logic [ADDR_W-1:0] sram_addr;
  wire  [15:0]       sram_data;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
`ifdef SRAM_WRITE_EN
  logic              wr_req;
  logic [15:0]       wr_addr;
  logic [15:0]       wr_data;
  logic              wr_done;

  modport slave (
    input  addr, ram_need_to_work, wr_req, wr_addr, wr_data,
    output ram_work_done, ram_feed_back, wr_done,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );

  modport master (
    output addr, ram_need_to_work, wr_req, wr_addr, wr_data,
    input  ram_work_done, ram_feed_back, wr_done,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );
`else
  modport slave (
    input  addr, ram_need_to_work,
    output ram_work_done, ram_feed_back,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );

  modport master (
    output addr, ram_need_to_work,
    input  ram_work_done, ram_feed_back,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n,
    inout  sram_data
  );
`endif
endinterface

// File: rtl/inst_sram_ctrl.sv
// RAM-side responder for instruction fetches: runs an async-SRAM read and returns the word with a level done flag.
// Define SRAM_WRITE_EN to add the write port and WRITE state.
module inst_sram_ctrl #(
  parameter int                 ADDR_W      = 18,
  parameter logic [ADDR_W-17:0] BANK        = '0,
  parameter int                 WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  inst_sram_if.slave bus
);

`ifdef SRAM_WRITE_EN
  typedef enum logic [1:0] {IDLE, READ, DONE, WRITE} state_e;
`else
  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;
`endif

  localparam logic [15:0] NOP_WORD = 16'h0800;
  localparam logic [3:0]  LAST_RD  = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         held_addr_q, held_addr_d;
  logic                done_q, done_d;
  logic [15:0]         fb_q, fb_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                read_start;

`ifdef SRAM_WRITE_EN
  localparam logic [3:0] LAST_WR = 4'(WAIT_CYCLES);

  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_done_q, wr_done_d;
  logic        write_start;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_addr_d = held_addr_q;
    done_d      = done_q;
    fb_d        = fb_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    sram_addr_d = sram_addr_q;
    read_start  = 1'b0;
`ifdef SRAM_WRITE_EN
    we_n_d      = we_n_q;
    drive_d     = drive_q;
    wdata_d     = wdata_q;
    wr_done_d   = 1'b0;
    write_start = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ram_need_to_work) read_start = 1'b1;
`ifdef SRAM_WRITE_EN
        else if (bus.wr_req) write_start = 1'b1;
`endif
      end
      READ: begin
        if (cnt_q == LAST_RD) begin
          fb_d    = bus.sram_data;
          done_d  = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // Same address again is the requester lagging a cycle, not a new fetch.
        if (bus.ram_need_to_work && (bus.addr != held_addr_q)) read_start = 1'b1;
`ifdef SRAM_WRITE_EN
        else if (bus.wr_req) write_start = 1'b1;
`endif
      end
`ifdef SRAM_WRITE_EN
      WRITE: begin
        // cnt 0 is the setup cycle; we_n is low while cnt runs 1..WAIT_CYCLES.
        if (cnt_q == 4'd0) begin
          we_n_d = 1'b0;
          cnt_d  = 4'd1;
        end else if (cnt_q == LAST_WR) begin
          we_n_d    = 1'b1;
          ce_n_d    = 1'b1;
          drive_d   = 1'b0;
          wr_done_d = 1'b1;
          done_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (read_start) begin
      state_d     = READ;
      held_addr_d = bus.addr;
      sram_addr_d = {BANK, bus.addr};
      ce_n_d      = 1'b0;
      oe_n_d      = 1'b0;
      cnt_d       = 4'd0;
      done_d      = 1'b0;
    end
`ifdef SRAM_WRITE_EN
    if (write_start) begin
      state_d     = WRITE;
      sram_addr_d = {BANK, bus.wr_addr};
      wdata_d     = bus.wr_data;
      drive_d     = 1'b1;
      ce_n_d      = 1'b0;
      cnt_d       = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      held_addr_q <= 16'h0000;
      done_q      <= 1'b0;
      fb_q        <= NOP_WORD;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      sram_addr_q <= '0;
`ifdef SRAM_WRITE_EN
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      wdata_q     <= 16'h0000;
      wr_done_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_addr_q <= held_addr_d;
      done_q      <= done_d;
      fb_q        <= fb_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      sram_addr_q <= sram_addr_d;
`ifdef SRAM_WRITE_EN
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      wdata_q     <= wdata_d;
      wr_done_q   <= wr_done_d;
`endif
    end
  end

  assign bus.ram_work_done = done_q;
  assign bus.ram_feed_back = fb_q;
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
`ifdef SRAM_WRITE_EN
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_data     = drive_q ? wdata_q : 16'hzzzz;
  assign bus.wr_done       = wr_done_q;
`else
  assign bus.sram_we_n     = 1'b1;
`endif

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed bench for inst_sram_ctrl with a small async-SRAM model; write tests build with SRAM_WRITE_EN.
module tb_inst_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] mem [0:255];

  inst_sram_if #(.ADDR_W(18)) bus ();

  inst_sram_ctrl #(.ADDR_W(18), .BANK(2'b00), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus while selected and output-enabled.
  assign bus.sram_data = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[7:0]] : 16'hzzzz;

`ifdef SRAM_WRITE_EN
  always @(posedge clk)
    if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr[7:0]] <= bus.sram_data;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h10] = 16'h4A05;
    mem[8'h11] = 16'h6B02;
    mem[8'h30] = 16'h1234;
    bus.addr             = 16'h0000;
    bus.ram_need_to_work = 1'b0;
`ifdef SRAM_WRITE_EN
    bus.wr_req  = 1'b0;
    bus.wr_addr = 16'h0000;
    bus.wr_data = 16'h0000;
`endif

    // Reset state
    repeat (2) tick();
    check("rst_done", 32'(bus.ram_work_done), 32'd0);
    check("rst_fb",   32'(bus.ram_feed_back), 32'h0800);
    check("rst_ce",   32'(bus.sram_ce_n), 32'd1);
    check("rst_oe",   32'(bus.sram_oe_n), 32'd1);
    check("rst_we",   32'(bus.sram_we_n), 32'd1);
    check("rst_addr", 32'(bus.sram_addr), 32'h0);
    #2 rst = 1'b0;

    // 1: basic read, latency WAIT_CYCLES
    tick();
    bus.addr = 16'h0010; bus.ram_need_to_work = 1'b1;
    tick();
    check("t1_oe_e0",   32'(bus.sram_oe_n), 32'd0);
    check("t1_ce_e0",   32'(bus.sram_ce_n), 32'd0);
    check("t1_addr",    32'(bus.sram_addr), 32'h00010);
    check("t1_done_e0", 32'(bus.ram_work_done), 32'd0);
    tick();
    check("t1_oe_e1",   32'(bus.sram_oe_n), 32'd0);
    check("t1_done_e1", 32'(bus.ram_work_done), 32'd0);
    tick();
    check("t1_done",    32'(bus.ram_work_done), 32'd1);
    check("t1_fb",      32'(bus.ram_feed_back), 32'h4A05);
    check("t1_oe_off",  32'(bus.sram_oe_n), 32'd1);

    // 2: drop req, then new address
    bus.ram_need_to_work = 1'b0;
    tick();
    check("t2_hold_done", 32'(bus.ram_work_done), 32'd1);
    check("t2_hold_fb",   32'(bus.ram_feed_back), 32'h4A05);
    bus.addr = 16'h0011; bus.ram_need_to_work = 1'b1;
    tick();
    check("t2_done_fall", 32'(bus.ram_work_done), 32'd0);
    check("t2_addr",      32'(bus.sram_addr), 32'h00011);
    tick();
    check("t2_done_mid",  32'(bus.ram_work_done), 32'd0);
    tick();
    check("t2_done",      32'(bus.ram_work_done), 32'd1);
    check("t2_fb",        32'(bus.ram_feed_back), 32'h6B02);

    // 3: same address held with req high, no re-access
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_done", 32'(bus.ram_work_done), 32'd1);
      check("t3_oe",   32'(bus.sram_oe_n), 32'd1);
      check("t3_fb",   32'(bus.ram_feed_back), 32'h6B02);
    end

    // 4: reset mid-read, then full-latency refetch
    bus.addr = 16'h0010;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t4_rst_done", 32'(bus.ram_work_done), 32'd0);
    check("t4_rst_fb",   32'(bus.ram_feed_back), 32'h0800);
    check("t4_rst_ce",   32'(bus.sram_ce_n), 32'd1);
    check("t4_rst_oe",   32'(bus.sram_oe_n), 32'd1);
    tick();
    #2 rst = 1'b0;
    tick();
    check("t4_oe_e0",   32'(bus.sram_oe_n), 32'd0);
    check("t4_done_e0", 32'(bus.ram_work_done), 32'd0);
    tick();
    check("t4_done_e1", 32'(bus.ram_work_done), 32'd0);
    tick();
    check("t4_done",    32'(bus.ram_work_done), 32'd1);
    check("t4_fb",      32'(bus.ram_feed_back), 32'h4A05);

`ifdef SRAM_WRITE_EN
    begin
      int we_low, pulses, seen;
      bus.ram_need_to_work = 1'b0;
      #2 rst = 1'b1;
      tick();
      #2 rst = 1'b0;

      // 5: write from IDLE, then read back
      bus.wr_addr = 16'h0020; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
      we_low = 0; pulses = 0; seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (!bus.sram_we_n) begin
          we_low++;
          check("t5_bus", 32'(bus.sram_data), 32'hBEEF);
        end
        if (bus.wr_done) begin
          pulses++;
          bus.wr_req = 1'b0;
        end
      end
      check("t5_we_low", 32'(we_low), 32'd2);
      check("t5_pulses", 32'(pulses), 32'd1);
      bus.addr = 16'h0020; bus.ram_need_to_work = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        tick();
        if (bus.ram_work_done) seen = 1;
      end
      check("t5_rd_done", 32'(seen), 32'd1);
      check("t5_rd_fb",   32'(bus.ram_feed_back), 32'hBEEF);

      // 6: simultaneous read and write requests in IDLE
      bus.ram_need_to_work = 1'b0;
      #2 rst = 1'b1;
      tick();
      #2 rst = 1'b0;
      bus.addr = 16'h0030; bus.ram_need_to_work = 1'b1;
      bus.wr_addr = 16'h0030; bus.wr_data = 16'h5678; bus.wr_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        tick();
        if (bus.ram_work_done) seen = 1;
      end
      check("t6_rd1_done", 32'(seen), 32'd1);
      check("t6_rd1_fb",   32'(bus.ram_feed_back), 32'h1234);
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        tick();
        if (bus.wr_done) seen = 1;
      end
      check("t6_wr_done",  32'(seen), 32'd1);
      check("t6_done_low", 32'(bus.ram_work_done), 32'd0);
      bus.wr_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        tick();
        if (bus.ram_work_done) seen = 1;
      end
      check("t6_rd2_done", 32'(seen), 32'd1);
      check("t6_rd2_fb",   32'(bus.ram_feed_back), 32'h5678);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
